// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU memory stage vs. burst DMA engine.
// Ports: cpu_* pipeline side, dma_* burst engine, mem_* single-port memory.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_start,
  input  logic             dma_write,
  input  logic [31:0]      dma_base,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_beat,
  output logic [31:0]      dma_rdata,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [31:2]      addr_q;
  logic [LEN_W-1:0] remain_q;
  logic             wr_q;
  logic [3:0]       wait_q;
  logic             cpu_req;
  logic             beat;

  assign cpu_req = cpu_read | cpu_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    beat     = 1'b0;
    unique case (state)
      IDLE: begin
        if (dma_start)
          state_nx = (dma_len != '0) ? ACTIVE : DONE;
      end
      ACTIVE: begin
        // DMA takes the beat when the CPU is idle or has
        // won MAX_WAIT cycles in a row.
        beat = !cpu_req || (wait_q >= WAIT_MAX);
        if (beat && remain_q == ONE)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
      wr_q     <= 1'b0;
      wait_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dma_start) begin
            addr_q   <= dma_base[31:2];
            remain_q <= dma_len;
            wr_q     <= dma_write;
            wait_q   <= '0;
          end
        end
        ACTIVE: begin
          if (beat) begin
            addr_q   <= addr_q + 30'd1;
            remain_q <= remain_q - ONE;
            wait_q   <= '0;
          end else begin
            wait_q   <= wait_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dma_beat  = beat;
  assign cpu_stall = beat & cpu_req;
  assign dma_busy  = (state != IDLE);
  assign dma_done  = (state == DONE);
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_read;
    mem_write = cpu_write;
    unique case (1'b1)
      beat: begin
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = dma_wdata;
        mem_read  = ~wr_q;
        mem_write = wr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Behavioural word memory; hand-computed expectations.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_start;
  logic        dma_write;
  logic [31:0] dma_base;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_beat;
  logic [31:0] dma_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.MAX_WAIT(4), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_start (dma_start),
    .dma_write (dma_write),
    .dma_base  (dma_base),
    .dma_len   (dma_len),
    .dma_wdata (dma_wdata),
    .dma_beat  (dma_beat),
    .dma_rdata (dma_rdata),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic f;
    reset     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = 32'h1234;
    cpu_wdata = 32'h0;
    dma_start = 1'b0;
    dma_write = 1'b0;
    dma_base  = 32'h0;
    dma_len   = 4'd0;
    dma_wdata = 32'h0;
    #2;
    check("rst_busy", dma_busy, 0);
    check("rst_done", dma_done, 0);
    check("rst_beat", dma_beat, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_rd", mem_read, 0);
    check("rst_wr", mem_write, 0);
    check("rst_addr", mem_addr, 32'h1234);
    tick();
    reset = 1'b0;

    // write burst, base bits[1:0] must be dropped
    tick();
    dma_start = 1'b1;
    dma_write = 1'b1;
    dma_base  = 32'h1000000B;
    dma_len   = 4'd3;
    #1;
    check("wr_start_busy", dma_busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_start = 1'b0;
      dma_wdata = 32'hA + i;
      #1;
      check("wr_beat", dma_beat, 1);
      check("wr_addr", mem_addr, 32'h10000008 + 4 * i);
      check("wr_we", mem_write, 1);
      check("wr_re", mem_read, 0);
      check("wr_data", mem_wdata, 32'hA + i);
      check("wr_busy", dma_busy, 1);
    end
    tick();
    dma_wdata = 32'h0;
    #1;
    check("wr_done", dma_done, 1);
    check("wr_done_beat", dma_beat, 0);
    check("wr_done_we", mem_write, 0);
    tick();
    #1;
    check("wr_post_done", dma_done, 0);
    check("wr_post_busy", dma_busy, 0);

    // read-back burst
    tick();
    dma_start = 1'b1;
    dma_write = 1'b0;
    dma_base  = 32'h10000008;
    dma_len   = 4'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_start = 1'b0;
      #1;
      check("rd_beat", dma_beat, 1);
      check("rd_re", mem_read, 1);
      check("rd_data", dma_rdata, 32'hA + i);
    end
    tick();
    #1;
    check("rd_done", dma_done, 1);

    // contention: CPU reading every cycle
    tick();
    cpu_read  = 1'b1;
    cpu_addr  = 32'h200;
    dma_start = 1'b1;
    dma_write = 1'b0;
    dma_base  = 32'h10000008;
    dma_len   = 4'd2;
    #1;
    check("ct_idle_addr", mem_addr, 32'h200);
    for (int k = 1; k <= 10; k++) begin
      tick();
      dma_start = 1'b0;
      #1;
      f = (k % 5 == 0);
      check("ct_beat", dma_beat, f);
      check("ct_stall", cpu_stall, f);
      check("ct_done", dma_done, 0);
      if (f) begin
        check("ct_daddr", mem_addr,
              (k == 5) ? 32'h10000008 : 32'h1000000C);
        check("ct_rdata", dma_rdata, (k == 5) ? 32'hA : 32'hB);
      end else begin
        check("ct_caddr", mem_addr, 32'h200);
      end
    end
    tick();
    #1;
    check("ct_done11", dma_done, 1);
    check("ct_stall_done", cpu_stall, 0);
    check("ct_addr_done", mem_addr, 32'h200);
    cpu_read = 1'b0;

    // asynchronous reset in the middle of a burst
    tick();
    dma_start = 1'b1;
    dma_write = 1'b0;
    dma_base  = 32'h10000008;
    dma_len   = 4'd3;
    #1;
    tick();
    dma_start = 1'b0;
    #1;
    check("ar_beat_pre", dma_beat, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", dma_busy, 0);
    check("ar_beat", dma_beat, 0);
    check("ar_rd", mem_read, 0);
    check("ar_stall", cpu_stall, 0);
    tick();
    reset = 1'b0;
    #1;
    check("ar_nodone1", dma_done, 0);
    check("ar_busy1", dma_busy, 0);
    tick();
    #1;
    check("ar_nodone2", dma_done, 0);
    tick();
    dma_start = 1'b1;
    dma_write = 1'b1;
    dma_base  = 32'h20;
    dma_len   = 4'd1;
    #1;
    tick();
    dma_start = 1'b0;
    dma_wdata = 32'h77;
    #1;
    check("ar_new_beat", dma_beat, 1);
    check("ar_new_addr", mem_addr, 32'h20);
    check("ar_new_we", mem_write, 1);
    tick();
    #1;
    check("ar_new_done", dma_done, 1);

    // zero-length burst; start while busy is ignored
    tick();
    dma_start = 1'b1;
    dma_write = 1'b1;
    dma_base  = 32'h300;
    dma_len   = 4'd0;
    #1;
    tick();
    dma_base  = 32'h400;
    dma_len   = 4'd5;
    #1;
    check("z_done", dma_done, 1);
    check("z_busy", dma_busy, 1);
    check("z_beat", dma_beat, 0);
    check("z_we", mem_write, 0);
    check("z_re", mem_read, 0);
    tick();
    dma_start = 1'b0;
    #1;
    check("z_idle_busy", dma_busy, 0);
    check("z_idle_done", dma_done, 0);
    tick();
    #1;
    check("z_ign_busy", dma_busy, 0);
    check("z_ign_beat", dma_beat, 0);

    // address wrap plus a CPU store mid-burst
    tick();
    dma_start = 1'b1;
    dma_write = 1'b1;
    dma_base  = 32'hFFFFFFFC;
    dma_len   = 4'd2;
    #1;
    tick();
    dma_start = 1'b0;
    dma_wdata = 32'h11;
    #1;
    check("wp_addr0", mem_addr, 32'hFFFFFFFC);
    check("wp_beat0", dma_beat, 1);
    tick();
    cpu_write = 1'b1;
    cpu_addr  = 32'h100;
    cpu_wdata = 32'h55;
    #1;
    check("wp_cpu_beat", dma_beat, 0);
    check("wp_cpu_stall", cpu_stall, 0);
    check("wp_cpu_addr", mem_addr, 32'h100);
    check("wp_cpu_we", mem_write, 1);
    check("wp_cpu_data", mem_wdata, 32'h55);
    tick();
    cpu_write = 1'b0;
    dma_wdata = 32'h22;
    #1;
    check("wp_addr1", mem_addr, 32'h0);
    check("wp_beat1", dma_beat, 1);
    check("wp_data1", mem_wdata, 32'h22);
    tick();
    cpu_read = 1'b1;
    cpu_addr = 32'h100;
    #1;
    check("wp_done", dma_done, 1);
    check("wp_cpu_rd", cpu_rdata, 32'h55);
    tick();
    cpu_read = 1'b0;
    cpu_addr = 32'hFFFFFFFC;
    #1;
    check("wp_mem_hi", mem_rdata, 32'h11);
    cpu_addr = 32'h0;
    #1;
    check("wp_mem_lo", mem_rdata, 32'h22);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
